// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU operation set and reset vector for the MIPS subset.
// Pure declarations, no latency.
// No flow control.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_harvard_cpu_if.sv
// Instruction fetch and data memory bus between the CPU and its memories.
// Purely combinational paths, no latency.
// No backpressure: both memories answer in the same cycle.
interface mips_harvard_cpu_if;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport master (
    output instr_address, data_address, data_write, data_read, data_writedata,
    input  instr_readdata, data_readdata
  );

  modport slave (
    input  instr_address, data_address, data_write, data_read, data_writedata,
    output instr_readdata, data_readdata
  );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data RAM with combinational read and clocked write.
// Read latency 0, write lands on the rising edge.
// No backpressure; clk_enable low freezes contents.
module data_memory #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        clk_enable,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic        data_write,
  input  logic        data_read,
  output logic [31:0] data_readdata
);
  localparam int IW = $clog2(DMEM_WORDS);

  logic [31:0]   r_mem [DMEM_WORDS];
  logic [IW-1:0] w_idx;
  logic          w_unused;

  assign w_idx    = data_address[IW+1:2];
  assign w_unused = ^{data_address[31:IW+2], data_address[1:0], data_read};

  // Storage: cleared by reset, written on enabled store strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) r_mem[i] <= '0;
    end else if (clk_enable && data_write) begin
      r_mem[w_idx] <= data_writedata;
    end
  end

  assign data_readdata = r_mem[w_idx];
endmodule

// File: rtl/mips_alu.sv
// Integer ALU: add/sub, logic ops, set-less-than, shifts by shamt, LUI placement.
// Combinational, zero latency.
// No flow control.
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_t     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_result,
  output logic        o_zero
);
  // Operation select; shifts act on the b operand (rt).
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_result = {31'd0, i_a < i_b};
      ALU_SLL:  o_result = i_b << i_shamt;
      ALU_SRL:  o_result = i_b >> i_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_b) >>> i_shamt);
      ALU_LUI:  o_result = {i_b[15:0], 16'h0000};
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == 32'd0);
endmodule

// File: rtl/mips_harvard_cpu.sv
// Single-cycle MIPS-I subset core with one branch delay slot and separate I/D buses.
// CPI 1: results are architecturally visible the cycle after the instruction.
// No backpressure; clk_enable low freezes PC and GPRs, fetch at PC 0 halts.
module mips_harvard_cpu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  output logic               active,
  output logic [31:0]        register_v0,
  mips_harvard_cpu_if.master bus
);
  logic [31:0] r_pc, r_npc;
  logic [31:0] r_regs [32];

  logic [31:0] w_instr, w_rs_val, w_rt_val, w_imm32, w_alu_b, w_alu_result;
  logic [31:0] w_pc_plus4, w_wb_data, w_jump_target, w_npc_next;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_wr_addr;
  alu_op_t     w_alu_op;
  wb_sel_t     w_wb_sel;
  logic        w_use_imm, w_wr_en, w_mem_rd, w_mem_wr, w_is_beq, w_is_bne, w_jump;
  logic        w_alu_zero, w_taken, w_rf_we;

  assign w_instr    = bus.instr_readdata;
  assign w_opcode   = w_instr[31:26];
  assign w_rs       = w_instr[25:21];
  assign w_rt       = w_instr[20:16];
  assign w_rd       = w_instr[15:11];
  assign w_shamt    = w_instr[10:6];
  assign w_funct    = w_instr[5:0];
  assign w_rs_val   = r_regs[w_rs];
  assign w_rt_val   = r_regs[w_rt];
  assign w_pc_plus4 = r_pc + 32'd4;

  // Decode: ALU operation, operand source, writeback target and control transfer.
  always_comb begin
    w_alu_op      = ALU_ADD;
    w_use_imm     = 1'b0;
    w_imm32       = sext16(w_instr[15:0]);
    w_wr_en       = 1'b0;
    w_wr_addr     = w_rd;
    w_wb_sel      = WB_ALU;
    w_mem_rd      = 1'b0;
    w_mem_wr      = 1'b0;
    w_is_beq      = 1'b0;
    w_is_bne      = 1'b0;
    w_jump        = 1'b0;
    w_jump_target = w_rs_val;
    case (w_opcode)
      OP_SPECIAL: begin
        w_wr_en = 1'b1;
        case (w_funct)
          FN_SLL:  w_alu_op = ALU_SLL;
          FN_SRL:  w_alu_op = ALU_SRL;
          FN_SRA:  w_alu_op = ALU_SRA;
          FN_ADDU: w_alu_op = ALU_ADD;
          FN_SUBU: w_alu_op = ALU_SUB;
          FN_AND:  w_alu_op = ALU_AND;
          FN_OR:   w_alu_op = ALU_OR;
          FN_XOR:  w_alu_op = ALU_XOR;
          FN_NOR:  w_alu_op = ALU_NOR;
          FN_SLT:  w_alu_op = ALU_SLT;
          FN_SLTU: w_alu_op = ALU_SLTU;
          FN_JR:   begin w_jump = 1'b1; w_wr_en = 1'b0; end
          FN_JALR: begin w_jump = 1'b1; w_wb_sel = WB_LINK; end
          default: w_wr_en = 1'b0;
        endcase
      end
      OP_J:     begin w_jump = 1'b1; w_jump_target = {w_pc_plus4[31:28], w_instr[25:0], 2'b00}; end
      OP_JAL:   begin
        w_jump = 1'b1; w_jump_target = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
        w_wr_en = 1'b1; w_wr_addr = 5'd31; w_wb_sel = WB_LINK;
      end
      OP_BEQ:   begin w_alu_op = ALU_SUB; w_is_beq = 1'b1; end
      OP_BNE:   begin w_alu_op = ALU_SUB; w_is_bne = 1'b1; end
      OP_ADDIU: begin w_use_imm = 1'b1; w_wr_en = 1'b1; w_wr_addr = w_rt; end
      OP_SLTI:  begin w_alu_op = ALU_SLT;  w_use_imm = 1'b1; w_wr_en = 1'b1; w_wr_addr = w_rt; end
      OP_SLTIU: begin w_alu_op = ALU_SLTU; w_use_imm = 1'b1; w_wr_en = 1'b1; w_wr_addr = w_rt; end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_alu_op  = (w_opcode == OP_ANDI) ? ALU_AND :
                    (w_opcode == OP_ORI)  ? ALU_OR  :
                    (w_opcode == OP_XORI) ? ALU_XOR : ALU_LUI;
        w_imm32   = {16'h0000, w_instr[15:0]};
        w_use_imm = 1'b1; w_wr_en = 1'b1; w_wr_addr = w_rt;
      end
      OP_LW:    begin
        w_use_imm = 1'b1; w_wr_en = 1'b1; w_wr_addr = w_rt;
        w_wb_sel = WB_MEM; w_mem_rd = 1'b1;
      end
      OP_SW:    begin w_use_imm = 1'b1; w_mem_wr = 1'b1; end
      default:  ;
    endcase
  end

  assign w_alu_b = w_use_imm ? w_imm32 : w_rt_val;

  mips_alu u_alu (
    .i_op     (w_alu_op),
    .i_a      (w_rs_val),
    .i_b      (w_alu_b),
    .i_shamt  (w_shamt),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  // The delay slot falls out of the PC/next-PC pair: a taken transfer only redirects next-PC.
  assign w_taken    = w_jump | (w_is_beq & w_alu_zero) | (w_is_bne & ~w_alu_zero);
  assign w_npc_next = !w_taken ? r_npc + 32'd4 :
                      w_jump   ? w_jump_target :
                                 w_pc_plus4 + {w_imm32[29:0], 2'b00};

  assign active  = (r_pc != 32'd0);
  assign w_rf_we = w_wr_en & active & clk_enable & (w_wr_addr != 5'd0);

  // Writeback source select: ALU result, load data or return address.
  always_comb begin
    w_wb_data = w_alu_result;
    case (w_wb_sel)
      WB_MEM:  w_wb_data = bus.data_readdata;
      WB_LINK: w_wb_data = r_pc + 32'd8;
      default: w_wb_data = w_alu_result;
    endcase
  end

  // Program counter pair; once PC reaches 0 it stays there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= RESET_VECTOR;
      r_npc <= RESET_VECTOR + 32'd4;
    end else if (clk_enable && active) begin
      r_pc  <= r_npc;
      r_npc <= w_npc_next;
    end
  end

  // Register file; $0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_rf_we) begin
      r_regs[w_wr_addr] <= w_wb_data;
    end
  end

  assign register_v0        = r_regs[2];
  assign bus.instr_address  = r_pc;
  assign bus.data_address   = w_alu_result;
  assign bus.data_writedata = w_rt_val;
  assign bus.data_write     = w_mem_wr & active;
  assign bus.data_read      = w_mem_rd & active;
endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Self-checking bench: small programs in a bench ROM, expected $v0 queued per program.
// Each program runs until fetch reaches address 0, then the queued result is compared.
// Also covers reset values, clk_enable freeze and asynchronous mid-run reset.
module tb_mips_harvard_cpu;
  localparam logic [31:0] VEC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] rom [64];
  logic [31:0] sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  mips_harvard_cpu_if bus ();

  mips_harvard_cpu #(.RESET_VECTOR(VEC)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .active      (active),
    .register_v0 (register_v0),
    .bus         (bus)
  );

  data_memory #(.DMEM_WORDS(1024)) dmem (
    .clk            (clk),
    .clk_enable     (clk_enable),
    .reset          (reset),
    .data_address   (bus.data_address),
    .data_writedata (bus.data_writedata),
    .data_write     (bus.data_write),
    .data_read      (bus.data_read),
    .data_readdata  (bus.data_readdata)
  );

  assign bus.instr_readdata = (bus.instr_address[31:8] == VEC[31:8]) ? rom[bus.instr_address[7:2]] : 32'h0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [31:0] JR0 = 32'h00000008;
  localparam logic [31:0] NOP = 32'h00000000;

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = NOP;
  endtask

  // Called at a negedge: pulse reset low across one clock edge.
  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, output int n_wr);
    int cyc;
    logic [31:0] exp;
    cyc  = 0;
    n_wr = 0;
    while (bus.instr_address != 32'd0 && cyc < 300) begin
      if (bus.data_write) n_wr++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_halt_pc"}, bus.instr_address, 32'd0);
    chk({tag, "_active"}, {31'd0, active}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, bus.data_write, bus.data_read}, 32'd0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_v0"}, register_v0, exp);
    end
  endtask

  initial begin
    int          nwr;
    logic [31:0] jt;
    clear_rom();
    @(negedge clk);
    #1;
    chk("rst_pc", bus.instr_address, VEC);
    chk("rst_active", {31'd0, active}, 32'd1);
    chk("rst_v0", register_v0, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // SLT false
    clear_rom();
    rom[0] = enc_i(6'h09, 0, 2, 16'd3);
    rom[1] = enc_i(6'h09, 4, 4, 16'd11);
    rom[2] = enc_i(6'h09, 5, 5, 16'd77);
    rom[3] = enc_r(5, 4, 2, 0, 6'h2A);
    rom[4] = JR0; rom[5] = NOP;
    sb_q.push_back(32'd0);
    do_reset(); run_to_halt("slt_false", nwr);

    // SLT true (signed)
    clear_rom();
    rom[0] = enc_i(6'h09, 0, 4, 16'hFFFF);
    rom[1] = enc_i(6'h09, 0, 5, 16'd1);
    rom[2] = enc_r(4, 5, 2, 0, 6'h2A);
    rom[3] = JR0; rom[4] = NOP;
    sb_q.push_back(32'd1);
    do_reset(); run_to_halt("slt_true", nwr);

    // SLTU with same operands is false
    clear_rom();
    rom[0] = enc_i(6'h09, 0, 2, 16'd7);
    rom[1] = enc_i(6'h09, 0, 4, 16'hFFFF);
    rom[2] = enc_i(6'h09, 0, 5, 16'd1);
    rom[3] = enc_r(4, 5, 2, 0, 6'h2B);
    rom[4] = JR0; rom[5] = NOP;
    sb_q.push_back(32'd0);
    do_reset(); run_to_halt("sltu", nwr);

    // Store then immediate load of the same word
    clear_rom();
    rom[0] = enc_i(6'h0F, 0, 5, 16'd0);
    rom[1] = enc_i(6'h09, 0, 6, 16'h1234);
    rom[2] = enc_i(6'h2B, 5, 6, 16'd8);
    rom[3] = enc_i(6'h23, 5, 2, 16'd8);
    rom[4] = JR0; rom[5] = NOP;
    sb_q.push_back(32'h00001234);
    do_reset(); run_to_halt("ld_st", nwr);
    chk("ld_st_nwr", nwr, 32'd1);

    // Memory is cleared by reset
    clear_rom();
    rom[0] = enc_i(6'h09, 0, 2, 16'd3);
    rom[1] = enc_i(6'h23, 0, 2, 16'd8);
    rom[2] = JR0; rom[3] = NOP;
    sb_q.push_back(32'd0);
    do_reset(); run_to_halt("mem_rst", nwr);

    // Branch delay slot
    clear_rom();
    rom[0] = enc_i(6'h04, 0, 0, 16'd2);
    rom[1] = enc_i(6'h09, 0, 2, 16'd5);
    rom[2] = enc_i(6'h09, 0, 2, 16'd9);
    rom[3] = enc_i(6'h09, 2, 2, 16'd1);
    rom[4] = JR0; rom[5] = NOP;
    sb_q.push_back(32'd6);
    do_reset(); run_to_halt("beq_slot", nwr);

    // Wrap-around, plus one-cycle visibility
    clear_rom();
    rom[0] = enc_i(6'h09, 0, 2, 16'hFFFF);
    rom[1] = enc_i(6'h09, 2, 2, 16'd1);
    rom[2] = JR0; rom[3] = NOP;
    sb_q.push_back(32'd0);
    do_reset();
    @(negedge clk);
    chk("wrap_step1", register_v0, 32'hFFFFFFFF);
    run_to_halt("wrap", nwr);

    // Shifts and XOR: -16 sra 2 = FFFFFFFC, srl 4 = 0FFFFFFF, xor = F0000003
    clear_rom();
    rom[0] = enc_i(6'h09, 0, 3, 16'hFFF0);
    rom[1] = enc_r(0, 3, 2, 2, 6'h03);
    rom[2] = enc_r(0, 3, 7, 4, 6'h02);
    rom[3] = enc_r(2, 7, 2, 0, 6'h26);
    rom[4] = JR0; rom[5] = NOP;
    sb_q.push_back(32'hF0000003);
    do_reset(); run_to_halt("shift", nwr);

    // LUI/ORI zero-extend, $0 write dropped, unknown opcode is NOP
    clear_rom();
    rom[0] = enc_i(6'h09, 0, 0, 16'd5);
    rom[1] = enc_i(6'h0F, 0, 3, 16'h1234);
    rom[2] = enc_i(6'h0D, 3, 2, 16'h8001);
    rom[3] = enc_i(6'h3F, 0, 2, 16'h5555);
    rom[4] = enc_r(2, 0, 2, 0, 6'h21);
    rom[5] = JR0; rom[6] = NOP;
    sb_q.push_back(32'h12348001);
    do_reset(); run_to_halt("lui_ori", nwr);

    // JAL link value and jump over skipped word
    clear_rom();
    jt = VEC + 32'd12;
    rom[0] = {6'h03, jt[27:2]};
    rom[1] = NOP;
    rom[2] = enc_i(6'h09, 0, 2, 16'd1);
    rom[3] = enc_r(31, 0, 2, 0, 6'h21);
    rom[4] = JR0; rom[5] = NOP;
    sb_q.push_back(VEC + 32'd8);
    do_reset(); run_to_halt("jal", nwr);

    // clk_enable freeze then asynchronous mid-run reset
    clear_rom();
    rom[0] = enc_i(6'h09, 0, 2, 16'd42);
    rom[1] = enc_i(6'h09, 0, 3, 16'd1);
    rom[2] = enc_i(6'h09, 0, 2, 16'd43);
    do_reset();
    @(negedge clk);
    @(negedge clk);
    chk("ce_pre_pc", bus.instr_address, VEC + 32'd8);
    clk_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("ce_hold_pc", bus.instr_address, VEC + 32'd8);
    chk("ce_hold_v0", register_v0, 32'd42);
    clk_enable = 1'b1;
    @(negedge clk);
    chk("ce_resume_pc", bus.instr_address, VEC + 32'd12);
    chk("ce_resume_v0", register_v0, 32'd43);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pc", bus.instr_address, VEC);
    chk("arst_v0", register_v0, 32'd0);
    chk("arst_active", {31'd0, active}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
